// File: rtl/score_controller.sv
// Rhythm-game score controller: per-lane hit/miss capture, round-robin service onto one
// saturating score register, and a sequential double-dabble conversion to three BCD digits.
module score_controller #(
   parameter int NUM_LANES    = 4,
   parameter int SCORE_W      = 10,
   parameter int MAX_SCORE    = 999,
   parameter int HIT_POINTS   = 1,
   parameter int MISS_PENALTY = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic [NUM_LANES-1:0] hit_i,
   input  logic [NUM_LANES-1:0] miss_i,
   output logic [NUM_LANES-1:0] grant_o,
   output logic                 overflow_o,
   output logic [SCORE_W-1:0]   score_o,
   output logic [3:0]           bcd_hundreds_o,
   output logic [3:0]           bcd_tens_o,
   output logic [3:0]           bcd_ones_o,
   output logic                 bcd_valid_o,
   output logic                 busy_o
);

   localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int CNT_W = $clog2(SCORE_W + 1);
   localparam logic [SCORE_W:0] HIT_X = (SCORE_W+1)'(HIT_POINTS);
   localparam logic [SCORE_W:0] PEN_X = (SCORE_W+1)'(MISS_PENALTY);
   localparam logic [SCORE_W:0] MAX_X = (SCORE_W+1)'(MAX_SCORE);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   logic [NUM_LANES-1:0] slot_vld_q, slot_vld_d, slot_miss_q, slot_miss_d, drop;
   logic [PTR_W-1:0]     ptr_q, ptr_d, sel;
   logic                 found, svc;
   logic [NUM_LANES-1:0] grant_q, grant_d;
   logic                 overflow_q;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 dirty_q, dirty_d;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [SCORE_W-1:0]   snap_q;
   logic [11:0]          acc_q, acc_adj;
   logic [11:0]          bcd_q;
   logic                 bcd_valid_q;
   logic                 load_snap, do_shift, load_out;

   // First valid slot at or after the round-robin pointer.
   always_comb begin : arb
      int               idx;
      logic [PTR_W-1:0] idx_w;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      idx_w = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx   = (int'(ptr_q) + k) % NUM_LANES;
         idx_w = PTR_W'(idx);
         if (!found && slot_vld_q[idx_w]) begin
            found = 1'b1;
            sel   = idx_w;
         end
      end
   end

   assign svc = found & ~clear_i;

   always_comb begin
      grant_d = '0;
      if (svc) grant_d[sel] = 1'b1;
   end

   // A granted slot frees up at the same edge, so a new pulse on that lane is never lost.
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic ev;
      assign ev              = hit_i[gi] | miss_i[gi];
      assign drop[gi]        = ~clear_i & ev & slot_vld_q[gi] & ~grant_d[gi];
      assign slot_vld_d[gi]  = clear_i ? 1'b0 : (ev | (slot_vld_q[gi] & ~grant_d[gi]));
      assign slot_miss_d[gi] = (~clear_i & ev & ~drop[gi]) ? miss_i[gi] : slot_miss_q[gi];
   end

   always_comb begin
      logic [SCORE_W:0] sum, diff;
      sum     = {1'b0, score_q} + HIT_X;
      diff    = {1'b0, score_q} - PEN_X;
      score_d = score_q;
      ptr_d   = ptr_q;
      if (clear_i) begin
         score_d = '0;
         ptr_d   = '0;
      end else if (svc) begin
         ptr_d = (sel == PTR_W'(NUM_LANES - 1)) ? '0 : sel + 1'b1;
         if (slot_miss_q[sel]) score_d = diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
         else                  score_d = (sum > MAX_X) ? MAX_X[SCORE_W-1:0] : sum[SCORE_W-1:0];
      end
   end

   // A new service outranks the snapshot's clear of dirty.
   always_comb begin
      dirty_d = dirty_q;
      if (clear_i)                dirty_d = 1'b0;
      else if (svc)               dirty_d = 1'b1;
      else if (state_q == S_IDLE) dirty_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_i) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE:  if (dirty_q) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      load_snap = (state_q == S_IDLE) & dirty_q;
      do_shift  = (state_q == S_SHIFT);
      load_out  = (state_q == S_DONE);
      busy_o    = dirty_q | (state_q != S_IDLE);
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                             : acc_q[4*gi +: 4];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_vld_q  <= '0;
         slot_miss_q <= '0;
         ptr_q       <= '0;
         grant_q     <= '0;
         overflow_q  <= 1'b0;
         score_q     <= '0;
         dirty_q     <= 1'b0;
         cnt_q       <= '0;
         snap_q      <= '0;
         acc_q       <= '0;
         bcd_q       <= '0;
         bcd_valid_q <= 1'b0;
      end else begin
         slot_vld_q  <= slot_vld_d;
         slot_miss_q <= slot_miss_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         overflow_q  <= |drop;
         score_q     <= score_d;
         dirty_q     <= dirty_d;
         bcd_valid_q <= load_out & ~clear_i;
         if (clear_i) begin
            cnt_q  <= '0;
            snap_q <= '0;
            acc_q  <= '0;
            bcd_q  <= '0;
         end else if (load_snap) begin
            cnt_q  <= '0;
            snap_q <= score_q;
            acc_q  <= '0;
         end else if (do_shift) begin
            cnt_q  <= cnt_q + 1'b1;
            snap_q <= snap_q << 1;
            acc_q  <= {acc_adj[10:0], snap_q[SCORE_W-1]};
         end else if (load_out) begin
            bcd_q  <= acc_q;
         end
      end
   end

   assign grant_o        = grant_q;
   assign overflow_o     = overflow_q;
   assign score_o        = score_q;
   assign bcd_hundreds_o = bcd_q[11:8];
   assign bcd_tens_o     = bcd_q[7:4];
   assign bcd_ones_o     = bcd_q[3:0];
   assign bcd_valid_o    = bcd_valid_q;

endmodule
